// File: rtl/pmod_led_arbiter_pkg.sv
// Shared definitions for the PMOD/LED ownership arbiter: state encoding,
// default timing constants and the pmod bus bit-to-connector-pin map.
package pmod_led_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned TICK_DIV_DEFAULT    = 32'd48000;
  localparam int unsigned SLICE_TICKS_DEFAULT = 32'd100;

  // Connector pin number driven by each pmod bus bit (bit 0 -> pmod_a1).
  localparam logic [7:0][3:0] PMOD_PIN_MAP = {4'd10, 4'd9, 4'd8, 4'd7,
                                              4'd4, 4'd3, 4'd2, 4'd1};

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pmod_led_arbiter_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV clk48 cycles,
// on the cycle its count sits at DIV-1.
module tick_prescaler #(
  parameter int unsigned DIV = 32'd48000
) (
  input  logic clk48,
  input  logic resetn,
  output logic tick
);

  localparam int unsigned CW = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;

  // Next count with wrap at DIV-1
  always_comb begin
    cnt_s = cnt_r;
    if (cnt_r == CW'(DIV - 32'd1)) begin
      cnt_s = {CW{1'b0}};
    end else begin
      cnt_s = cnt_r + CW'(1);
    end
  end

  // Count register; tick is registered so it lines up with the count value
  always_ff @(posedge clk48) begin
    if (!resetn) begin
      cnt_r <= {CW{1'b0}};
      tick  <= (DIV == 32'd1);
    end else begin
      cnt_r <= cnt_s;
      tick  <= (cnt_s == CW'(DIV - 32'd1));
    end
  end

endmodule

// File: rtl/pmod_led_arbiter.sv
// Two-requester round-robin arbiter for the PMOD header and onboard LED, with
// timesliced preemption and a one-cycle break-before-make gap between owners.
module pmod_led_arbiter
  import pmod_led_arbiter_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TICK_DIV_DEFAULT,
  parameter int unsigned SLICE_TICKS = SLICE_TICKS_DEFAULT
) (
  input  logic       clk48,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic [7:0] pat0,
  input  logic [7:0] pat1,
  output logic [1:0] gnt,
  output logic [7:0] pmod,
  output logic       led,
  output logic       busy
);

  localparam int unsigned SW = $clog2(SLICE_TICKS + 32'd1);

  state_t        state_r;
  state_t        state_s;
  logic          owner_r;
  logic          owner_s;
  logic          rr_last_r;
  logic [SW-1:0] slice_r;
  logic [28:0]   idle_cnt_r;
  logic          tick_s;
  logic          other_s;
  logic          slice_full_s;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk48  (clk48),
    .resetn (resetn),
    .tick   (tick_s)
  );

  assign other_s      = ~owner_r;
  assign slice_full_s = (slice_r == SW'(SLICE_TICKS));

  // Next-state and winner selection
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    case (state_r)
      IDLE: begin
        if (req != 2'b00) begin
          state_s = OWN;
          // On a tie the requester that did not own last time wins
          if (req == 2'b11) begin
            owner_s = ~rr_last_r;
          end else begin
            owner_s = req[1];
          end
        end else begin
          state_s = IDLE;
        end
      end
      OWN: begin
        if (!req[owner_r] || (slice_full_s && req[other_s])) begin
          state_s = GAP;
        end else begin
          state_s = OWN;
        end
      end
      GAP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Arbitration state, round-robin history and slice accounting
  always_ff @(posedge clk48) begin
    if (!resetn) begin
      state_r   <= IDLE;
      owner_r   <= 1'b0;
      rr_last_r <= 1'b1;
      slice_r   <= {SW{1'b0}};
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      if (state_r == OWN) begin
        rr_last_r <= owner_r;
      end else begin
        rr_last_r <= rr_last_r;
      end
      if (state_r != OWN) begin
        slice_r <= {SW{1'b0}};
      end else if (tick_s && !slice_full_s) begin
        slice_r <= slice_r + SW'(1);
      end else begin
        slice_r <= slice_r;
      end
    end
  end

  // Idle animation counter, never stalled by arbitration
  always_ff @(posedge clk48) begin
    if (!resetn) begin
      idle_cnt_r <= 29'd0;
    end else begin
      idle_cnt_r <= idle_cnt_r + 29'd1;
    end
  end

  // Registered pin drive; grant and busy follow the state being entered
  always_ff @(posedge clk48) begin
    if (!resetn) begin
      gnt  <= 2'b00;
      busy <= 1'b0;
      pmod <= 8'h00;
      led  <= 1'b1;
    end else begin
      gnt  <= (state_s == OWN) ? owner_onehot(owner_s) : 2'b00;
      busy <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          pmod <= idle_cnt_r[28:21];
          led  <= ~idle_cnt_r[25];
        end
        OWN: begin
          pmod <= owner_r ? pat1 : pat0;
          led  <= 1'b1;
        end
        GAP: begin
          pmod <= 8'h00;
          led  <= 1'b0;
        end
        default: begin
          pmod <= 8'h00;
          led  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_led_arbiter.sv
// Scoreboard bench: a behavioural model queues the expected outputs for each
// cycle as stimulus is applied; a monitor pops and compares after each edge.
module tb_pmod_led_arbiter;

  localparam int DIV = 4;
  localparam int SL  = 3;

  logic       clk48  = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] req    = 2'b00;
  logic [7:0] pat0   = 8'h00;
  logic [7:0] pat1   = 8'h00;
  logic [1:0] gnt;
  logic [7:0] pmod;
  logic       led;
  logic       busy;

  pmod_led_arbiter #(.TICK_DIV(DIV), .SLICE_TICKS(SL)) dut (
    .clk48  (clk48),
    .resetn (resetn),
    .req    (req),
    .pat0   (pat0),
    .pat1   (pat1),
    .gnt    (gnt),
    .pmod   (pmod),
    .led    (led),
    .busy   (busy)
  );

  always #5 clk48 = ~clk48;

  typedef struct packed {
    logic [1:0] gnt;
    logic [7:0] pmod;
    logic       led;
    logic       busy;
    logic       tick;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: mode 0 = nobody holds the pins, 1 = owned, 2 = handover gap
  int          m_mode  = 0;
  int          m_owner = 0;
  int          m_slice = 0;
  int          m_last  = 1;
  logic [28:0] m_cyc   = 29'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req_v, $time);
    end
  endtask

  // Advance the model by one clock using the inputs just applied
  task automatic step_model();
    exp_t e;
    logic tick_now;
    int   other;
    e = '0;
    if (!resetn) begin
      m_mode  = 0;
      m_owner = 0;
      m_slice = 0;
      m_last  = 1;
      m_cyc   = 29'd0;
      e.pmod  = 8'h00;
      e.led   = 1'b1;
    end else begin
      tick_now = ((m_cyc % DIV) == DIV - 1);
      if (m_mode == 0) begin
        e.pmod = m_cyc[28:21];
        e.led  = ~m_cyc[25];
      end else if (m_mode == 1) begin
        e.pmod = (m_owner == 1) ? pat1 : pat0;
        e.led  = 1'b1;
      end else begin
        e.pmod = 8'h00;
        e.led  = 1'b0;
      end
      if (m_mode == 0) begin
        if (req != 2'b00) begin
          if (req == 2'b11) m_owner = 1 - m_last;
          else              m_owner = req[1] ? 1 : 0;
          m_mode  = 1;
          m_slice = 0;
        end
      end else if (m_mode == 1) begin
        m_last = m_owner;
        other  = 1 - m_owner;
        if (!req[m_owner] || (m_slice == SL && req[other])) m_mode = 2;
        else if (tick_now && m_slice < SL) m_slice++;
      end else begin
        m_mode = 0;
      end
      m_cyc = m_cyc + 29'd1;
    end
    e.gnt  = (m_mode == 1) ? (2'b01 << m_owner) : 2'b00;
    e.busy = (m_mode != 0);
    e.tick = ((m_cyc % DIV) == DIV - 1);
    e.last = m_last[0];
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rn, input logic [1:0] r, input logic [7:0] p0, input logic [7:0] p1);
    @(negedge clk48);
    resetn = rn;
    req    = r;
    pat0   = p0;
    pat1   = p1;
    step_model();
  endtask

  // Monitor: compare every presented cycle against the oldest expectation
  always @(posedge clk48) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt",     32'(gnt),                   32'(e.gnt));
      chk("pmod",    32'(pmod),                  32'(e.pmod));
      chk("led",     32'(led),                   32'(e.led));
      chk("busy",    32'(busy),                  32'(e.busy));
      chk("tick",    32'(dut.u_prescaler.tick),  32'(e.tick));
      chk("rr_last", 32'(dut.rr_last_r),         32'(e.last));
    end
  end

  initial begin
    logic [1:0] r;
    logic       rn;

    // Reset, then idle with no requests
    repeat (3) drive(1'b0, 2'b00, 8'h00, 8'h00);
    repeat (20) drive(1'b1, 2'b00, 8'($urandom), 8'($urandom));

    // Single requester 0 with a fixed pattern, then release
    repeat (10) drive(1'b1, 2'b01, 8'hA5, 8'($urandom));
    repeat (5) drive(1'b1, 2'b00, 8'hA5, 8'($urandom));

    // Both requesting from reset: timesliced alternation
    repeat (2) drive(1'b0, 2'b00, 8'h00, 8'h00);
    repeat (120) drive(1'b1, 2'b11, 8'($urandom), 8'($urandom));

    // Lone requester holds well past its slice
    repeat (2) drive(1'b0, 2'b00, 8'h00, 8'h00);
    repeat (50 * DIV + 10) drive(1'b1, 2'b01, 8'($urandom), 8'($urandom));

    // Owner drops on the very cycle its slice expires while the other waits
    repeat (2) drive(1'b0, 2'b00, 8'h00, 8'h00);
    for (int i = 0; i < 80; i++) begin
      r = 2'b11;
      if (m_mode == 1 && m_slice == SL) r[m_owner] = 1'b0;
      drive(1'b1, r, 8'($urandom), 8'($urandom));
    end

    // Reset pulse while owned
    repeat (2) drive(1'b0, 2'b00, 8'h00, 8'h00);
    repeat (5) drive(1'b1, 2'b10, 8'($urandom), 8'h3C);
    drive(1'b0, 2'b10, 8'($urandom), 8'h3C);
    repeat (3) drive(1'b1, 2'b00, 8'($urandom), 8'($urandom));

    // Randomized traffic with sticky requests and rare resets
    r = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r = 2'($urandom_range(0, 3));
      rn = ($urandom_range(0, 299) != 0);
      drive(rn, r, 8'($urandom), 8'($urandom));
    end
    repeat (2) drive(1'b1, 2'b00, 8'h00, 8'h00);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk48);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
